// File: rtl/wshb_arbiter_2m.sv
// wshb_arbiter_2m
// Two-master, one-slave Wishbone arbiter for the SDRAM bus (sys_clk domain).
// Master 0 is the frame-buffer writer, master 1 the vga reader. Grants are
// round-robin and are held for a whole Wishbone cycle (while cyc is high), so
// bursts are never split. A master that keeps cyc high forever starves the
// other one; the masters bound their own bursts.
//
// Ports:
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   m{0,1}_cyc/stb/we/adr/
//     dat_ms/sel/cti/bte        master requests
//   m{0,1}_ack/err/rty/dat_sm   responses back to each master
//   s_cyc/stb/we/adr/dat_ms/
//     sel/cti/bte               request to the SDRAM slave
//   s_ack/err/rty/dat_sm        slave responses
//   gnt                         one-hot grant (bit0 = m0, bit1 = m1, 00 = idle)
//   ack_cnt0, ack_cnt1          16-bit wrapping ack counters, present only
//                               when WSHB_ARB_STATS_EN is defined
//
// Optional feature macro: WSHB_ARB_STATS_EN (default build: undefined).

module wshb_arbiter_2m #(
  parameter int ADR_W = 32,
  parameter int DAT_W = 32
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  // master 0
  input  logic               m0_cyc,
  input  logic               m0_stb,
  input  logic               m0_we,
  input  logic [ADR_W-1:0]   m0_adr,
  input  logic [DAT_W-1:0]   m0_dat_ms,
  input  logic [DAT_W/8-1:0] m0_sel,
  input  logic [2:0]         m0_cti,
  input  logic [1:0]         m0_bte,
  output logic               m0_ack,
  output logic               m0_err,
  output logic               m0_rty,
  output logic [DAT_W-1:0]   m0_dat_sm,
  // master 1
  input  logic               m1_cyc,
  input  logic               m1_stb,
  input  logic               m1_we,
  input  logic [ADR_W-1:0]   m1_adr,
  input  logic [DAT_W-1:0]   m1_dat_ms,
  input  logic [DAT_W/8-1:0] m1_sel,
  input  logic [2:0]         m1_cti,
  input  logic [1:0]         m1_bte,
  output logic               m1_ack,
  output logic               m1_err,
  output logic               m1_rty,
  output logic [DAT_W-1:0]   m1_dat_sm,
  // slave
  output logic               s_cyc,
  output logic               s_stb,
  output logic               s_we,
  output logic [ADR_W-1:0]   s_adr,
  output logic [DAT_W-1:0]   s_dat_ms,
  output logic [DAT_W/8-1:0] s_sel,
  output logic [2:0]         s_cti,
  output logic [1:0]         s_bte,
  input  logic               s_ack,
  input  logic               s_err,
  input  logic               s_rty,
  input  logic [DAT_W-1:0]   s_dat_sm,
`ifdef WSHB_ARB_STATS_EN
  output logic [15:0]        ack_cnt0,
  output logic [15:0]        ack_cnt1,
`endif
  output logic [1:0]         gnt
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e state_q, state_d;
  logic   last_q,  last_d;   // index of the master served most recently

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc) state_d = last_q ? GNT0 : GNT1;
        else if (m0_cyc)      state_d = GNT0;
        else if (m1_cyc)      state_d = GNT1;
      end
      GNT0: begin
        // Release hands straight over to a waiting master: no idle bubble.
        if (!m0_cyc) begin
          last_d  = 1'b0;
          state_d = m1_cyc ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc) begin
          last_d  = 1'b1;
          state_d = m0_cyc ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last resets to 1 so that m0 wins the first tie.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  logic sel0, sel1;
  assign sel0 = (state_q == GNT0);
  assign sel1 = (state_q == GNT1);
  assign gnt  = {sel1, sel0};

  // Request mux: everything is forced low in IDLE, so an asynchronous reset
  // drops s_cyc/s_stb in the same cycle.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    if (sel0) begin
      s_cyc    = m0_cyc;
      s_stb    = m0_stb;
      s_we     = m0_we;
      s_adr    = m0_adr;
      s_dat_ms = m0_dat_ms;
      s_sel    = m0_sel;
      s_cti    = m0_cti;
      s_bte    = m0_bte;
    end else if (sel1) begin
      s_cyc    = m1_cyc;
      s_stb    = m1_stb;
      s_we     = m1_we;
      s_adr    = m1_adr;
      s_dat_ms = m1_dat_ms;
      s_sel    = m1_sel;
      s_cti    = m1_cti;
      s_bte    = m1_bte;
    end
  end

  // Responses go only to the granted master; spurious slave acks in IDLE
  // reach nobody.
  assign m0_ack    = sel0 & s_ack;
  assign m0_err    = sel0 & s_err;
  assign m0_rty    = sel0 & s_rty;
  assign m0_dat_sm = sel0 ? s_dat_sm : '0;
  assign m1_ack    = sel1 & s_ack;
  assign m1_err    = sel1 & s_err;
  assign m1_rty    = sel1 & s_rty;
  assign m1_dat_sm = sel1 ? s_dat_sm : '0;

`ifdef WSHB_ARB_STATS_EN
  logic [15:0] ack_cnt0_q, ack_cnt0_d;
  logic [15:0] ack_cnt1_q, ack_cnt1_d;

  // 16-bit counters wrap naturally from 0xFFFF to 0.
  always_comb begin
    ack_cnt0_d = ack_cnt0_q + {15'd0, m0_ack};
    ack_cnt1_d = ack_cnt1_q + {15'd0, m1_ack};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack_cnt0_q <= '0;
      ack_cnt1_q <= '0;
    end else begin
      ack_cnt0_q <= ack_cnt0_d;
      ack_cnt1_q <= ack_cnt1_d;
    end
  end

  assign ack_cnt0 = ack_cnt0_q;
  assign ack_cnt1 = ack_cnt1_q;
`endif

endmodule

// File: tb/tb_wshb_arbiter_2m.sv
// Directed testbench for wshb_arbiter_2m. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled on the falling edge (or a few units
// after an asynchronous event). The ack-counter scenario runs only when
// WSHB_ARB_STATS_EN is defined.

module tb_wshb_arbiter_2m;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n;
  logic               m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [ADR_W-1:0]   m0_adr, m1_adr;
  logic [DAT_W-1:0]   m0_dat_ms, m1_dat_ms;
  logic [DAT_W/8-1:0] m0_sel, m1_sel;
  logic [2:0]         m0_cti, m1_cti;
  logic [1:0]         m0_bte, m1_bte;
  logic               m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [DAT_W-1:0]   m0_dat_sm, m1_dat_sm;
  logic               s_cyc, s_stb, s_we;
  logic [ADR_W-1:0]   s_adr;
  logic [DAT_W-1:0]   s_dat_ms;
  logic [DAT_W/8-1:0] s_sel;
  logic [2:0]         s_cti;
  logic [1:0]         s_bte;
  logic               s_ack, s_err, s_rty;
  logic [DAT_W-1:0]   s_dat_sm;
  logic [1:0]         gnt;
`ifdef WSHB_ARB_STATS_EN
  logic [15:0]        ack_cnt0, ack_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  wshb_arbiter_2m #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
`ifdef WSHB_ARB_STATS_EN
    .ack_cnt0(ack_cnt0), .ack_cnt1(ack_cnt1),
`endif
    .gnt(gnt)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
    m0_adr = 32'h1000; m1_adr = 32'h2000;
    m0_dat_ms = 32'h0000_00D0; m1_dat_ms = 32'h0000_00D1;
    m0_sel = 4'hF; m1_sel = 4'h3;
    m0_cti = 3'b000; m1_cti = 3'b000; m0_bte = 2'b00; m1_bte = 2'b00;
    s_ack = 1'b1; s_err = 1'b0; s_rty = 1'b0; s_dat_sm = 32'h55;
    #3;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b expected 0", s_cyc); end
    checks++; if ({m0_ack, m1_ack} !== 2'b00) begin errors++; $display("FAIL reset_spurious_ack: got %b expected 00", {m0_ack, m1_ack}); end
    checks++; if (m0_dat_sm !== 32'h0) begin errors++; $display("FAIL reset_m0_dat: got %h expected 0", m0_dat_sm); end
    s_ack = 1'b0;
    tick();
  endtask

  // Both request before reset release; m0 wins, then hands over to m1.
  task automatic test_tie_handover();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL tie_latency: got s_cyc %b expected 0", s_cyc); end
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL tie_gnt: got %b expected 01", gnt); end
    checks++; if (s_adr !== 32'h1000) begin errors++; $display("FAIL tie_adr: got %h expected 00001000", s_adr); end
    checks++; if (s_sel !== 4'hF) begin errors++; $display("FAIL tie_sel: got %h expected f", s_sel); end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL handover_gnt: got %b expected 10", gnt); end
    checks++; if (s_adr !== 32'h2000) begin errors++; $display("FAIL handover_adr: got %h expected 00002000", s_adr); end
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL release_idle: got %b expected 00", gnt); end
  endtask

  task automatic test_m1_burst();
    int n_ack = 0;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 32'h3000; m1_cti = 3'b010;
    s_ack = 1'b1; s_dat_sm = 32'h99;
    @(negedge sys_clk);
    checks++; if (m1_ack !== 1'b0) begin errors++; $display("FAIL idle_spurious_ack: got %b expected 0", m1_ack); end
    tick();
    for (int i = 0; i < 4; i++) begin
      m1_cti = (i == 3) ? 3'b111 : 3'b010;
      s_dat_sm = 32'hA0 + i;
      @(negedge sys_clk);
      if (m1_ack === 1'b1) n_ack++;
      checks++; if (m1_dat_sm !== 32'hA0 + i) begin errors++; $display("FAIL burst_dat%0d: got %h expected %h", i, m1_dat_sm, 32'hA0 + i); end
      checks++; if ({m0_ack, m0_dat_sm} !== 33'h0) begin errors++; $display("FAIL burst_m0_quiet%0d: got ack %b dat %h expected 0", i, m0_ack, m0_dat_sm); end
      checks++; if (s_cti !== m1_cti) begin errors++; $display("FAIL burst_cti%0d: got %b expected %b", i, s_cti, m1_cti); end
      tick();
    end
    checks++; if (n_ack != 4) begin errors++; $display("FAIL burst_ack_count: got %0d expected 4", n_ack); end
    s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; m1_cti = 3'b000;
    tick();
  endtask

  // m1 asks mid-burst; m0 keeps the grant until it drops cyc.
  task automatic test_hold_grant();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1;
    tick();
    m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b1; s_err = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL hold_gnt%0d: got %b expected 01", i, gnt); end
      checks++; if ({m1_ack, m1_err, m0_ack, m0_err} !== 4'b0011) begin errors++; $display("FAIL hold_resp%0d: got %b expected 0011", i, {m1_ack, m1_err, m0_ack, m0_err}); end
      tick();
    end
    s_ack = 1'b0; s_err = 1'b0;
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL hold_release: got %b expected 10", gnt); end
    checks++; if (s_we !== 1'b0) begin errors++; $display("FAIL hold_release_we: got %b expected 0", s_we); end
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
  endtask

  // m0 served alone to IDLE (last = 0); a tie then goes to m1.
  task automatic test_last_tie();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL last_tie: got %b expected 10", gnt); end
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick();
    tick();
  endtask

  // Both keep requesting; each master completes a single write beat on the
  // combinational ack and withdraws cyc before the edge, re-raising after it.
  task automatic test_alternate();
    int n0 = 0, n1 = 0;
    logic [1:0] exp_g = 2'b01;
    m0_we = 1'b1; m1_we = 1'b1; s_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      if (k == 0) tick();
      @(negedge sys_clk);
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL alt_gnt%0d: got %b expected %b", k, gnt, exp_g); end
      checks++; if ({m1_ack, m0_ack} !== exp_g) begin errors++; $display("FAIL alt_ack%0d: got %b expected %b", k, {m1_ack, m0_ack}, exp_g); end
      if (gnt === 2'b01) begin n0++; m0_cyc = 1'b0; m0_stb = 1'b0; end
      if (gnt === 2'b10) begin n1++; m1_cyc = 1'b0; m1_stb = 1'b0; end
      exp_g = ~exp_g;
      tick();
    end
    checks++; if (n0 != 5 || n1 != 5) begin errors++; $display("FAIL alt_share: got %0d/%0d expected 5/5", n0, n1); end
    s_ack = 1'b0;
    {m0_cyc, m0_stb, m1_cyc, m1_stb, m0_we, m1_we} = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rmb_grant: got %b expected 10", gnt); end
    m0_cyc = 1'b1; m0_stb = 1'b1;
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++; if ({s_cyc, s_stb} !== 2'b00) begin errors++; $display("FAIL rmb_drop: got %b expected 00", {s_cyc, s_stb}); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rmb_gnt: got %b expected 00", gnt); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rmb_after: got %b expected 01", gnt); end
    {m0_cyc, m0_stb, m1_cyc, m1_stb} = '0;
    tick();
    tick();
  endtask

`ifdef WSHB_ARB_STATS_EN
  task automatic test_stats();
    checks++; if (ack_cnt0 !== 16'd0) begin errors++; $display("FAIL stats_start0: got %0d expected 0", ack_cnt0); end
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    s_ack = 1'b1;
    repeat (70000) @(posedge sys_clk);
    #1;
    s_ack = 1'b0;
    checks++; if (ack_cnt0 !== 16'd4464) begin errors++; $display("FAIL stats_cnt0: got %0d expected 4464", ack_cnt0); end
    checks++; if (ack_cnt1 !== 16'd0) begin errors++; $display("FAIL stats_cnt1: got %0d expected 0", ack_cnt1); end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_tie_handover();
    test_m1_burst();
    test_hold_grant();
    test_last_tie();
    test_alternate();
    test_reset_mid_burst();
`ifdef WSHB_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
